// File: rtl/if_fetch_ctrl_if.sv
// Fetch-side bus: icache request/response channel plus the IF/ID instruction handoff.
// Signal suffixes are named from the fetch controller's point of view.
interface if_fetch_ctrl_if #(
   parameter int XLEN = 64
) ();
   logic            ic_req_valid_o;
   logic [XLEN-1:0] ic_req_addr_o;
   logic            ic_req_ready_i;
   logic            ic_rsp_valid_i;
   logic [31:0]     ic_rsp_data_i;
   logic            inst_valid_o;
   logic [31:0]     inst_o;
   logic [XLEN-1:0] inst_pc_o;
   logic            id_ready_i;

   modport master (
      output ic_req_valid_o, ic_req_addr_o, inst_valid_o, inst_o, inst_pc_o,
      input  ic_req_ready_i, ic_rsp_valid_i, ic_rsp_data_i, id_ready_i
   );

   modport slave (
      input  ic_req_valid_o, ic_req_addr_o, inst_valid_o, inst_o, inst_pc_o,
      output ic_req_ready_i, ic_rsp_valid_i, ic_rsp_data_i, id_ready_i
   );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Fetch sequencer: one outstanding icache read, redirect kill of in-flight data, one-entry IF/ID buffer.
// Define FETCH_TIMEOUT_EN to build the sticky fetch watchdog; otherwise timeout_o is tied low.
module if_fetch_ctrl #(
   parameter int              XLEN        = 64,
   parameter logic [XLEN-1:0] RESET_PC    = 64'h8000_0000,
   parameter int              TIMEOUT_CYC = 255
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_next_i,
   input  logic            redirect_i,
   if_fetch_ctrl_if.master bus,
   output logic            fetch_stall_o,
   output logic            timeout_o
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, KILL, DRAIN} state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] addr_q;
   logic [XLEN-1:0] ipc_q;
   logic [31:0]     inst_q;
   logic            ivld_q;

   logic hs, rsp, load, consume, stall;

   assign hs      = (state_q == REQ) && bus.ic_req_ready_i;
   assign rsp     = bus.ic_rsp_valid_i;
   assign load    = (state_q == WAIT) && rsp && !redirect_i;
   assign consume = ivld_q && bus.id_ready_i;
   // PC register advances on a buffered response or follows any redirect
   assign stall   = !(load || redirect_i);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = REQ;
         REQ:     if (hs) state_d = redirect_i ? KILL : WAIT;
         WAIT: begin
            if (rsp)             state_d = redirect_i ? REQ : DRAIN;
            else if (redirect_i) state_d = KILL;
         end
         KILL:    if (rsp) state_d = REQ;
         DRAIN:   if (!ivld_q || bus.id_ready_i || redirect_i) state_d = REQ;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= RESET_PC;
         ivld_q  <= 1'b0;
         inst_q  <= '0;
         ipc_q   <= '0;
      end else begin
         state_q <= state_d;
         if (!stall) addr_q <= pc_next_i;
         // a redirect flushes the buffer even when a response lands the same cycle
         if (redirect_i) begin
            ivld_q <= 1'b0;
         end else if (load) begin
            ivld_q <= 1'b1;
            inst_q <= bus.ic_rsp_data_i;
            ipc_q  <= addr_q;
         end else if (consume) begin
            ivld_q <= 1'b0;
         end
      end
   end

   assign bus.ic_req_valid_o = (state_q == REQ);
   assign bus.ic_req_addr_o  = addr_q;
   assign bus.inst_valid_o   = ivld_q;
   assign bus.inst_o         = inst_q;
   assign bus.inst_pc_o      = ipc_q;
   assign fetch_stall_o      = stall;

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

   logic [CNT_W-1:0] wd_cnt_q, wd_cnt_d;
   logic             wd_flag_q, wd_flag_d;
   logic             wd_active, wd_entry;

   assign wd_active = (state_q == WAIT) || (state_q == KILL);
   assign wd_entry  = (state_d != state_q) && ((state_d == WAIT) || (state_d == KILL));

   always_comb begin
      wd_cnt_d  = wd_cnt_q;
      wd_flag_d = wd_flag_q;
      if (wd_entry)
         wd_cnt_d = '0;
      else if (wd_active && (wd_cnt_q != CNT_W'(TIMEOUT_CYC)))
         wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_active && (wd_cnt_d == CNT_W'(TIMEOUT_CYC)))
         wd_flag_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wd_cnt_q  <= '0;
         wd_flag_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         wd_flag_q <= wd_flag_d;
      end
   end

   assign timeout_o = wd_flag_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scenario bench for if_fetch_ctrl: request/instruction scoreboards checked by a negedge monitor.
module tb_if_fetch_ctrl;
   localparam int          XLEN   = 64;
   localparam logic [63:0] RST_PC = 64'h8000_0000;
`ifdef FETCH_TIMEOUT_EN
   localparam logic TO_EXP = 1'b1;
`else
   localparam logic TO_EXP = 1'b0;
`endif

   logic        clk, rst, redirect, ready, rsp_v, id_ready, stall, timeout;
   logic [63:0] pc_next;
   logic [31:0] rsp_d;
   int          tests, fails, n_hs, n_inst;
   logic [63:0] exp_addr[$];
   logic [95:0] exp_inst[$];
   logic [63:0] ea;
   logic [95:0] ei;

   if_fetch_ctrl_if #(.XLEN(XLEN)) bus ();
   assign bus.ic_req_ready_i = ready;
   assign bus.ic_rsp_valid_i = rsp_v;
   assign bus.ic_rsp_data_i  = rsp_d;
   assign bus.id_ready_i     = id_ready;

   if_fetch_ctrl #(.XLEN(XLEN), .RESET_PC(RST_PC), .TIMEOUT_CYC(255)) dut (
      .clk(clk), .rst(rst), .pc_next_i(pc_next), .redirect_i(redirect),
      .bus(bus), .fetch_stall_o(stall), .timeout_o(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard monitor: every handshake and every consume must match the next expectation
   always @(negedge clk) begin
      if (rst) begin
         if (bus.ic_req_valid_o && ready) begin
            n_hs++;
            tests++;
            if (exp_addr.size() == 0) begin
               fails++; $display("FAIL sb_req unexpected handshake got=%h", bus.ic_req_addr_o);
            end else begin
               ea = exp_addr.pop_front();
               if (bus.ic_req_addr_o !== ea) begin
                  fails++; $display("FAIL sb_req_addr got=%h exp=%h", bus.ic_req_addr_o, ea);
               end
            end
         end
         if (bus.inst_valid_o && id_ready) begin
            n_inst++;
            tests++;
            if (exp_inst.size() == 0) begin
               fails++; $display("FAIL sb_inst unexpected inst got=%h pc=%h", bus.inst_o, bus.inst_pc_o);
            end else begin
               ei = exp_inst.pop_front();
               if ({bus.inst_o, bus.inst_pc_o} !== ei) begin
                  fails++; $display("FAIL sb_inst got=%h/%h exp=%h/%h", bus.inst_o, bus.inst_pc_o, ei[95:64], ei[63:0]);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic idle_inputs();
      redirect = 0; ready = 0; rsp_v = 0; rsp_d = '0; id_ready = 0; pc_next = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 0;
      @(negedge clk);
      tests++; if (bus.ic_req_valid_o !== 1'b0) begin fails++; $display("FAIL rst_req_valid got=%b exp=0", bus.ic_req_valid_o); end
      tests++; if (bus.ic_req_addr_o !== RST_PC) begin fails++; $display("FAIL rst_addr got=%h exp=%h", bus.ic_req_addr_o, RST_PC); end
      tests++; if ({bus.inst_valid_o, bus.inst_o, bus.inst_pc_o} !== 97'd0) begin fails++; $display("FAIL rst_buffer got=%b/%h/%h exp=0", bus.inst_valid_o, bus.inst_o, bus.inst_pc_o); end
      tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rst_stall got=%b exp=1", stall); end
   endtask

   task automatic test_basic();
      do_reset(); ready = 1; id_ready = 1;
      @(negedge clk);
      tests++; if ({bus.ic_req_valid_o, stall} !== 2'b01) begin fails++; $display("FAIL basic_idle got=%b exp=01", {bus.ic_req_valid_o, stall}); end
      cyc(); exp_addr.push_back(RST_PC);
      @(negedge clk);
      tests++; if ({bus.ic_req_valid_o, stall} !== 2'b11) begin fails++; $display("FAIL basic_req got=%b exp=11", {bus.ic_req_valid_o, stall}); end
      cyc(); ready = 0;
      @(negedge clk);
      tests++; if ({bus.ic_req_valid_o, stall, bus.inst_valid_o} !== 3'b010) begin fails++; $display("FAIL basic_wait got=%b exp=010", {bus.ic_req_valid_o, stall, bus.inst_valid_o}); end
      cyc(); rsp_v = 1; rsp_d = 32'h0000_0013; pc_next = RST_PC + 64'd4; exp_inst.push_back({32'h0000_0013, RST_PC});
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL basic_rsp_stall got=%b exp=0", stall); end
      cyc(); rsp_v = 0;
      @(negedge clk);
      tests++; if ({bus.inst_valid_o, bus.inst_o, bus.inst_pc_o} !== {1'b1, 32'h13, RST_PC}) begin fails++; $display("FAIL basic_inst got=%b/%h/%h exp=1/00000013/%h", bus.inst_valid_o, bus.inst_o, bus.inst_pc_o, RST_PC); end
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL basic_drain_stall got=%b exp=1", stall); end
      cyc();
      @(negedge clk);
      tests++; if (bus.ic_req_addr_o !== RST_PC + 64'd4) begin fails++; $display("FAIL basic_next_addr got=%h exp=%h", bus.ic_req_addr_o, RST_PC + 64'd4); end
   endtask

   task automatic test_ready_stall();
      int hs0;
      do_reset(); id_ready = 1;
      cyc(); exp_addr.push_back(RST_PC); hs0 = n_hs;
      for (int i = 0; i < 5; i++) begin
         pc_next = 64'hDEAD_0000 + 64'(i);
         @(negedge clk);
         tests++; if ({bus.ic_req_valid_o, bus.ic_req_addr_o} !== {1'b1, RST_PC}) begin fails++; $display("FAIL hold_req cyc=%0d got=%b/%h exp=1/%h", i, bus.ic_req_valid_o, bus.ic_req_addr_o, RST_PC); end
         cyc();
      end
      ready = 1;
      @(negedge clk);
      cyc();
      @(negedge clk);
      tests++; if (bus.ic_req_valid_o !== 1'b0) begin fails++; $display("FAIL hold_wait_req got=%b exp=0", bus.ic_req_valid_o); end
      tests++; if (n_hs - hs0 !== 1) begin fails++; $display("FAIL hold_hs_count got=%0d exp=1", n_hs - hs0); end
   endtask

   task automatic test_id_backpressure();
      do_reset(); ready = 1;
      cyc(); exp_addr.push_back(RST_PC);
      cyc(); rsp_v = 1; rsp_d = 32'h0050_0093; pc_next = RST_PC + 64'd4; exp_inst.push_back({32'h0050_0093, RST_PC});
      cyc(); rsp_v = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests++; if ({bus.inst_valid_o, bus.inst_o, bus.ic_req_valid_o} !== {1'b1, 32'h0050_0093, 1'b0}) begin fails++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b exp=1/00500093/0", i, bus.inst_valid_o, bus.inst_o, bus.ic_req_valid_o); end
         cyc();
      end
      id_ready = 1; exp_addr.push_back(RST_PC + 64'd4);
      @(negedge clk);
      cyc(); id_ready = 0;
      @(negedge clk);
      tests++; if ({bus.ic_req_valid_o, bus.inst_valid_o} !== 2'b10) begin fails++; $display("FAIL bp_after_consume got=%b exp=10", {bus.ic_req_valid_o, bus.inst_valid_o}); end
      cyc(); ready = 0;
   endtask

   task automatic test_redirect_wait();
      do_reset(); ready = 1; id_ready = 1;
      cyc(); exp_addr.push_back(RST_PC);
      cyc(); redirect = 1; pc_next = 64'h8000_0100;
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rw_stall got=%b exp=0", stall); end
      cyc(); redirect = 0; rsp_v = 1; rsp_d = 32'hDEAD_BEEF; pc_next = 64'h0000_0BAD;
      @(negedge clk);
      tests++; if ({stall, bus.inst_valid_o} !== 2'b10) begin fails++; $display("FAIL rw_kill got=%b exp=10", {stall, bus.inst_valid_o}); end
      cyc(); rsp_v = 0; exp_addr.push_back(64'h8000_0100);
      @(negedge clk);
      tests++; if ({bus.ic_req_valid_o, bus.inst_valid_o, bus.ic_req_addr_o} !== {2'b10, 64'h8000_0100}) begin fails++; $display("FAIL rw_refetch got=%b/%b/%h exp=1/0/80000100", bus.ic_req_valid_o, bus.inst_valid_o, bus.ic_req_addr_o); end
      cyc(); ready = 0;
   endtask

   task automatic test_redirect_rsp();
      do_reset(); ready = 1; id_ready = 1;
      cyc(); exp_addr.push_back(RST_PC);
      cyc(); rsp_v = 1; rsp_d = 32'h1111_1111; redirect = 1; pc_next = 64'h8000_0200;
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rr_stall got=%b exp=0", stall); end
      cyc(); rsp_v = 0; redirect = 0; exp_addr.push_back(64'h8000_0200);
      @(negedge clk);
      tests++; if ({bus.ic_req_valid_o, bus.inst_valid_o, bus.ic_req_addr_o} !== {2'b10, 64'h8000_0200}) begin fails++; $display("FAIL rr_refetch got=%b/%b/%h exp=1/0/80000200", bus.ic_req_valid_o, bus.inst_valid_o, bus.ic_req_addr_o); end
      cyc(); ready = 0;
   endtask

   task automatic test_redirect_req();
      do_reset(); id_ready = 1;
      cyc(); ready = 1; redirect = 1; pc_next = 64'h8000_0300; exp_addr.push_back(RST_PC);
      @(negedge clk);
      tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rq_stall got=%b exp=0", stall); end
      cyc(); redirect = 0;
      @(negedge clk);
      tests++; if (bus.ic_req_valid_o !== 1'b0) begin fails++; $display("FAIL rq_kill_req got=%b exp=0", bus.ic_req_valid_o); end
      cyc(); rsp_v = 1; rsp_d = 32'h2222_2222;
      @(negedge clk);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL rq_kill_stall got=%b exp=1", stall); end
      cyc(); rsp_v = 0; exp_addr.push_back(64'h8000_0300);
      @(negedge clk);
      tests++; if ({bus.inst_valid_o, bus.ic_req_addr_o} !== {1'b0, 64'h8000_0300}) begin fails++; $display("FAIL rq_refetch got=%b/%h exp=0/80000300", bus.inst_valid_o, bus.ic_req_addr_o); end
      cyc(); ready = 0;
   endtask

   task automatic test_back_to_back();
      int hs0, in0;
      logic [63:0] a;
      logic [31:0] d;
      do_reset(); ready = 1; id_ready = 1;
      cyc(); hs0 = n_hs; in0 = n_inst;
      for (int i = 0; i < 4; i++) begin
         a = RST_PC + 64'(4 * i);
         d = $urandom;
         exp_addr.push_back(a);
         cyc(); rsp_v = 1; rsp_d = d; pc_next = a + 64'd4; exp_inst.push_back({d, a});
         cyc(); rsp_v = 0;
         if (i == 3) ready = 0;
         cyc();
      end
      @(negedge clk);
      tests++; if (n_hs - hs0 !== 4) begin fails++; $display("FAIL b2b_hs got=%0d exp=4", n_hs - hs0); end
      tests++; if (n_inst - in0 !== 4) begin fails++; $display("FAIL b2b_inst got=%0d exp=4", n_inst - in0); end
   endtask

   task automatic test_reset_mid();
      do_reset(); ready = 1; id_ready = 1;
      cyc(); exp_addr.push_back(RST_PC);
      cyc(); rsp_v = 1; rsp_d = 32'h0010_0073; pc_next = RST_PC + 64'h40; exp_inst.push_back({32'h0010_0073, RST_PC});
      cyc(); rsp_v = 0; exp_addr.push_back(RST_PC + 64'h40);
      cyc();
      cyc(); ready = 0;
      @(negedge clk); rst = 0;
      #1;
      tests++; if ({bus.ic_req_valid_o, bus.inst_valid_o, bus.ic_req_addr_o} !== {2'b00, RST_PC}) begin fails++; $display("FAIL mid_rst got=%b/%b/%h exp=0/0/%h", bus.ic_req_valid_o, bus.inst_valid_o, bus.ic_req_addr_o, RST_PC); end
      cyc(); rst = 1; rsp_v = 1; rsp_d = 32'h0BAD_0BAD;
      @(negedge clk);
      tests++; if (stall !== 1'b1) begin fails++; $display("FAIL mid_stray_rsp_stall got=%b exp=1", stall); end
      cyc(); rsp_v = 0;
      @(negedge clk);
      tests++; if ({bus.ic_req_valid_o, bus.inst_valid_o, bus.ic_req_addr_o} !== {2'b10, RST_PC}) begin fails++; $display("FAIL mid_restart got=%b/%b/%h exp=1/0/%h", bus.ic_req_valid_o, bus.inst_valid_o, bus.ic_req_addr_o, RST_PC); end
      cyc(); ready = 1; exp_addr.push_back(RST_PC);
      cyc(); ready = 0;
      repeat (200) cyc();
      @(negedge clk);
      tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL wd_early got=%b exp=0", timeout); end
      repeat (60) cyc();
      @(negedge clk);
      tests++; if (timeout !== TO_EXP) begin fails++; $display("FAIL wd_fire got=%b exp=%b", timeout, TO_EXP); end
      cyc(); rsp_v = 1; rsp_d = 32'h0000_0001; exp_inst.push_back({32'h0000_0001, RST_PC});
      cyc(); rsp_v = 0;
      cyc();
      @(negedge clk);
      tests++; if (timeout !== TO_EXP) begin fails++; $display("FAIL wd_sticky got=%b exp=%b", timeout, TO_EXP); end
   endtask

   initial begin
      tests = 0; fails = 0; n_hs = 0; n_inst = 0;
      test_reset();
      test_basic();
      test_ready_stall();
      test_id_backpressure();
      test_redirect_wait();
      test_redirect_rsp();
      test_redirect_req();
      test_back_to_back();
      test_reset_mid();
      @(negedge clk);
      tests++; if (exp_addr.size() != 0) begin fails++; $display("FAIL sb_req_leftover got=%0d exp=0", exp_addr.size()); end
      tests++; if (exp_inst.size() != 0) begin fails++; $display("FAIL sb_inst_leftover got=%0d exp=0", exp_inst.size()); end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
